eq_training_sequencer: RTL and testbench

Sequencer for TX equalizer training: sweeps an equalizer coefficient code across a programmed range, requests one eye-opening measurement per code from the eye monitor, and keeps the code with the largest opening. On completion it applies the best code to the TX equalizer and reports pass/fail against a minimum-opening threshold. It sits between the link bring-up control and the TX equalization datapath and eye monitor, and replaces free-running gradient adjustment with a bounded, deterministic search.

---
 rtl/eq_training_sequencer_if.sv | 17 +
 rtl/eq_training_sequencer.sv | 107 ++++++++++
 tb/tb_eq_training_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/eq_training_sequencer_if.sv
// eq_training_sequencer_if: bring-up control, TX equalizer and eye-monitor signals of the training sequencer
interface eq_training_sequencer_if #(
  parameter int CODE_W = 6,
  parameter int OPEN_W = 12
);
  logic start, coeff_update, meas_req, meas_ready, busy, done, pass, timeout_err;
  logic [CODE_W-1:0] coeff, best_code;
  logic [OPEN_W-1:0] opening, best_opening;
  modport master (
    input  start, meas_ready, opening,
    output coeff, coeff_update, meas_req, busy, done, pass, best_code, best_opening, timeout_err
  );
  modport slave (
    output start, meas_ready, opening,
    input  coeff, coeff_update, meas_req, busy, done, pass, best_code, best_opening, timeout_err
  );
endinterface

// File: rtl/eq_training_sequencer.sv
// eq_training_sequencer: sweeps the TX-equalizer code, measures the eye per code and applies the widest-eye code
module eq_training_sequencer #(
  parameter int CODE_W         = 6,
  parameter int OPEN_W         = 12,
  parameter int CODE_MIN       = 0,
  parameter int CODE_MAX       = 63,
  parameter int STEP           = 4,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MIN_OPENING    = 200
) (
  input logic clk,
  input logic reset,
  eq_training_sequencer_if.master bus
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CODE_W:0] C_MAX = (CODE_W + 1)'(CODE_MAX);
  localparam logic [CODE_W-1:0] C_MIN = CODE_W'(CODE_MIN);
  localparam logic [OPEN_W-1:0] O_MIN = OPEN_W'(MIN_OPENING);
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, MEASURE, EVAL, FINAL, DONE, ERROR} state_t;
  state_t state;
  logic [CODE_W-1:0] code;
  logic [OPEN_W-1:0] meas;
  logic first;
  logic [SW-1:0] scnt;
  logic [TW-1:0] tcnt;
  logic [CODE_W:0] nxt;
  // one extra bit so a step past the top of the code range cannot wrap
  assign nxt = {1'b0, code} + (CODE_W + 1)'(STEP);
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      code             <= C_MIN;
      meas             <= '0;
      first            <= 1'b0;
      scnt             <= '0;
      tcnt             <= '0;
      bus.coeff        <= C_MIN;
      bus.coeff_update <= 1'b0;
      bus.meas_req     <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.pass         <= 1'b0;
      bus.best_code    <= C_MIN;
      bus.best_opening <= '0;
      bus.timeout_err  <= 1'b0;
    end else begin
      bus.coeff_update <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: if (bus.start) begin
          state            <= APPLY;
          bus.busy         <= 1'b1;
          bus.done         <= 1'b0;
          bus.pass         <= 1'b0;
          bus.timeout_err  <= 1'b0;
          bus.best_opening <= '0;
          bus.best_code    <= C_MIN;
          code             <= C_MIN;
          first            <= 1'b1;
        end
        APPLY: begin
          bus.coeff        <= code;
          bus.coeff_update <= 1'b1;
          scnt             <= '0;
          state            <= SETTLE;
        end
        SETTLE: if (scnt == S_LAST) begin
          state        <= MEASURE;
          bus.meas_req <= 1'b1;
          tcnt         <= '0;
        end else scnt <= scnt + 1'b1;
        // a ready on the last allowed cycle still wins over the timeout
        MEASURE: if (bus.meas_ready) begin
          meas         <= bus.opening;
          bus.meas_req <= 1'b0;
          state        <= EVAL;
        end else if (tcnt == T_LAST) begin
          bus.meas_req    <= 1'b0;
          bus.busy        <= 1'b0;
          bus.timeout_err <= 1'b1;
          state           <= ERROR;
        end else tcnt <= tcnt + 1'b1;
        EVAL: begin
          if (first || meas > bus.best_opening) begin
            bus.best_opening <= meas;
            bus.best_code    <= code;
          end
          first <= 1'b0;
          code  <= (nxt <= C_MAX) ? nxt[CODE_W-1:0] : code;
          state <= (nxt <= C_MAX) ? APPLY : FINAL;
        end
        FINAL: begin
          bus.coeff        <= bus.best_code;
          bus.coeff_update <= 1'b1;
          bus.busy         <= 1'b0;
          bus.done         <= 1'b1;
          bus.pass         <= bus.best_opening >= O_MIN;
          state            <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eq_training_sequencer.sv
// tb_eq_training_sequencer: scoreboarded sweep, tie, timeout, reset and range checks of the training sequencer
module tb_eq_training_sequencer;
  localparam int S = 3, T = 64;
  typedef struct {int code; int gap;} upd_t;
  logic clk = 1'b0, reset = 1'b1;
  int total = 0, bad = 0, cyc = 0, last_upd = 0;
  int b_cnt = 0, b_last = -1, c_cnt = 0, c_last = -1;
  upd_t exp_q[$];
  upd_t e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  eq_training_sequencer_if #(.CODE_W(6), .OPEN_W(12)) a_if ();
  eq_training_sequencer_if #(.CODE_W(6), .OPEN_W(12)) b_if ();
  eq_training_sequencer_if #(.CODE_W(6), .OPEN_W(12)) c_if ();
  eq_training_sequencer #(.CODE_MAX(12), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) u_a (.clk(clk), .reset(reset), .bus(a_if));
  eq_training_sequencer #(.CODE_MAX(10), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) u_b (.clk(clk), .reset(reset), .bus(b_if));
  eq_training_sequencer #(.CODE_MAX(63), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) u_c (.clk(clk), .reset(reset), .bus(c_if));
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (a_if.coeff_update) begin
      if (exp_q.size() == 0) check("upd_unexpected", int'(a_if.coeff), -1);
      else begin
        e = exp_q.pop_front();
        check("upd_code", int'(a_if.coeff), e.code);
        if (e.gap != 0) check("upd_gap", cyc - last_upd, e.gap);
      end
      last_upd = cyc;
    end
    if (a_if.done && a_if.busy) check("done_and_busy", 1, 0);
  end
  initial begin
    b_if.meas_ready = 1'b0;
    c_if.meas_ready = 1'b0;
    b_if.opening = '0;
    c_if.opening = '0;
    forever begin
      @(negedge clk);
      b_if.meas_ready = b_if.meas_req;
      b_if.opening = 12'(300 - 10 * int'(b_if.coeff));
      if (b_if.meas_req) begin b_cnt++; b_last = int'(b_if.coeff); end
      c_if.meas_ready = c_if.meas_req;
      c_if.opening = 12'(7 * int'(c_if.coeff));
      if (c_if.meas_req) begin c_cnt++; c_last = int'(c_if.coeff); end
    end
  end
  task automatic check_reset();
    check("rst_coeff", int'(a_if.coeff), 0);
    check("rst_update", int'(a_if.coeff_update), 0);
    check("rst_req", int'(a_if.meas_req), 0);
    check("rst_busy", int'(a_if.busy), 0);
    check("rst_done", int'(a_if.done), 0);
    check("rst_pass", int'(a_if.pass), 0);
    check("rst_best_code", int'(a_if.best_code), 0);
    check("rst_best_open", int'(a_if.best_opening), 0);
    check("rst_err", int'(a_if.timeout_err), 0);
  endtask
  task automatic do_sweep(input int op[4], input int dl[4], input int stall, input bit noise,
                          output int bc, output int bo);
    int n;
    bit first = 1'b1;
    upd_t u;
    bc = 0;
    bo = 0;
    for (int i = 0; i < 4 && (stall < 0 || i <= stall); i++) begin
      u.code = i * 4;
      u.gap = (i == 0) ? 0 : S + 3 + dl[i-1];
      exp_q.push_back(u);
      if (i != stall && (first || op[i] > bo)) begin bo = op[i]; bc = i * 4; first = 1'b0; end
    end
    if (stall < 0) begin
      u.code = bc;
      u.gap = S + 3 + dl[3];
      exp_q.push_back(u);
    end
    @(negedge clk) a_if.start = 1'b1;
    @(negedge clk) a_if.start = 1'b0;
    check("busy_on_start", int'(a_if.busy), 1);
    check("err_cleared", int'(a_if.timeout_err), 0);
    check("done_cleared", int'(a_if.done), 0);
    for (int i = 0; i < 4; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (noise && i < 2) begin
          a_if.meas_ready = (n == 1);
          a_if.start = (n == 1);
          a_if.opening = 12'hfff;
        end
      end while (!a_if.meas_req && n < 100);
      if (!a_if.meas_req) begin check("req_seen", 0, 1); return; end
      if (i == stall) return;
      repeat (dl[i]) @(negedge clk);
      check("req_held", int'(a_if.meas_req), 1);
      a_if.meas_ready = 1'b1;
      a_if.opening = 12'(op[i]);
      @(negedge clk) a_if.meas_ready = 1'b0;
    end
  endtask
  task automatic end_check(input int bc, input int bo);
    int n = 0;
    while (!a_if.done && !a_if.timeout_err && n < 500) begin @(negedge clk); n++; end
    check("done", int'(a_if.done), 1);
    check("busy_low", int'(a_if.busy), 0);
    check("best_code", int'(a_if.best_code), bc);
    check("best_open", int'(a_if.best_opening), bo);
    check("pass", int'(a_if.pass), int'(bo >= 200));
    check("coeff_final", int'(a_if.coeff), bc);
    @(negedge clk);
    check("upd_pending", exp_q.size(), 0);
  endtask
  initial begin
    int bc, bo, n;
    upd_t u;
    a_if.start = 1'b0;
    a_if.meas_ready = 1'b0;
    a_if.opening = '0;
    b_if.start = 1'b0;
    c_if.start = 1'b0;
    repeat (3) @(negedge clk);
    check_reset();
    reset = 1'b0;
    a_if.meas_ready = 1'b1;
    a_if.opening = 12'd4000;
    @(negedge clk) a_if.meas_ready = 1'b0;
    check("idle_ignores_ready", int'(a_if.busy), 0);
    b_if.start = 1'b1;
    c_if.start = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    c_if.start = 1'b0;
    do_sweep('{100, 300, 250, 50}, '{0, 1, 37, 0}, -1, 1'b0, bc, bo);
    end_check(bc, bo);
    n = 0;
    while (!c_if.done && n < 400) begin @(negedge clk); n++; end
    check("b_points", b_cnt, 3);
    check("b_last_code", b_last, 8);
    check("b_best_code", int'(b_if.best_code), 0);
    check("b_done", int'(b_if.done), 1);
    check("c_points", c_cnt, 16);
    check("c_last_code", c_last, 60);
    check("c_best_code", int'(c_if.best_code), 60);
    check("c_best_open", int'(c_if.best_opening), 420);
    check("c_pass", int'(c_if.pass), 1);
    do_sweep('{120, 150, 150, 90}, '{0, 0, 0, 0}, -1, 1'b1, bc, bo);
    end_check(bc, bo);
    do_sweep('{120, 150, 0, 0}, '{0, 0, 0, 0}, 2, 1'b0, bc, bo);
    n = 0;
    while (a_if.meas_req && n < T + 50) begin n++; @(negedge clk); end
    check("timeout_len", n, T);
    check("to_err", int'(a_if.timeout_err), 1);
    check("to_req", int'(a_if.meas_req), 0);
    check("to_busy", int'(a_if.busy), 0);
    check("to_done", int'(a_if.done), 0);
    check("to_coeff", int'(a_if.coeff), 8);
    check("to_best_code", int'(a_if.best_code), bc);
    check("to_best_open", int'(a_if.best_opening), bo);
    check("to_pending", exp_q.size(), 0);
    do_sweep('{100, 300, 250, 50}, '{0, 0, 0, 0}, -1, 1'b0, bc, bo);
    end_check(bc, bo);
    u.code = 0;
    u.gap = 0;
    exp_q.push_back(u);
    u.code = 4;
    u.gap = S + 3;
    exp_q.push_back(u);
    @(negedge clk) a_if.start = 1'b1;
    @(negedge clk) a_if.start = 1'b0;
    n = 0;
    while (!a_if.meas_req && n < 50) begin @(negedge clk); n++; end
    a_if.meas_ready = 1'b1;
    a_if.opening = 12'd500;
    @(negedge clk) a_if.meas_ready = 1'b0;
    n = 0;
    while (!a_if.coeff_update && n < 20) begin @(negedge clk); n++; end
    check("rst_in_settle_code", int'(a_if.coeff), 4);
    reset = 1'b1;
    @(negedge clk);
    check_reset();
    check("rst_pending", exp_q.size(), 0);
    reset = 1'b0;
    do_sweep('{100, 300, 250, 50}, '{1, 0, 0, 37}, -1, 1'b0, bc, bo);
    end_check(bc, bo);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
